// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with 50% duty for both even and odd ratios.
// Divisor changes are deferred to the period boundary, so clk_out never shows a short pulse.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             load_err
);

    if (DIV_W < 2 || DIV_W > 30) begin : g_bad_width
        $error("clk_div_prog: DIV_W out of range");
    end
    if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** DIV_W) - 1) begin : g_bad_default
        $error("clk_div_prog: DEFAULT_DIV out of range");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             p_q, p_d;
    logic             ack_idle_q, ack_idle_d;
    logic             load_err_q, load_err_d;
    logic             n_q;

    logic load_ok;
    logic last;
    logic wrap;

    always_comb begin
        load_ok    = div_load && (div_val >= TWO);
        last       = (cnt_q == div_q - ONE);
        wrap       = (state_q != IDLE) && last;

        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_idle_d = 1'b0;
        load_err_d = div_load && !load_ok;

        if (load_ok) begin
            pend_d     = div_val;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // No period in flight, so a divisor can go live immediately.
                if (load_ok) begin
                    div_d      = div_val;
                    pend_vld_d = 1'b0;
                    ack_idle_d = 1'b1;
                end else if (pend_vld_q) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                    ack_idle_d = 1'b1;
                end
                if (enable) state_d = RUN;
            end
            RUN: begin
                cnt_d = last ? '0 : cnt_q + ONE;
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = last ? '0 : cnt_q + ONE;
                if (enable)    state_d = RUN;
                else if (last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load landing in the wrap cycle stays pending for the next boundary.
        if (wrap && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = load_ok;
        end

        p_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DEF_DIV;
            pend_q     <= DEF_DIV;
            pend_vld_q <= 1'b0;
            p_q        <= 1'b0;
            ack_idle_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            p_q        <= p_d;
            ack_idle_q <= ack_idle_d;
            load_err_q <= load_err_d;
        end
    end

    // Half-cycle extension of p, used only for odd ratios.
    always_ff @(negedge clk_in) begin
        if (rst) n_q <= 1'b0;
        else     n_q <= p_q;
    end

    // Masking with rst can only pull the output low, so it cannot create a runt high pulse.
    assign clk_out  = (p_q | (div_q[0] & n_q)) & ~rst;
    assign tick     = wrap;
    assign load_ack = ack_idle_q | (wrap & pend_vld_q);
    assign load_err = load_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: edge timing of clk_out plus pulse counting on tick/load_ack/load_err.
module tb_clk_div_prog;

    logic       clk_in;
    logic       rst;
    logic       enable;
    logic [7:0] div_val;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic       load_ack;
    logic       load_err;

    int checks   = 0;
    int failures = 0;
    int n_tick   = 0;
    int n_ack    = 0;
    int n_err    = 0;
    int n_ackw   = 0;
    bit edge_hit;

    clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(7)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .load_ack (load_ack),
        .load_err (load_err)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        if (tick)             n_tick <= n_tick + 1;
        if (load_ack)         n_ack  <= n_ack + 1;
        if (load_err)         n_err  <= n_err + 1;
        if (load_ack && tick) n_ackw <= n_ackw + 1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_clk_out(input bit rise, input int lim, output bit ok);
        edge_hit = 1'b0;
        fork
            begin
                if (rise) @(posedge clk_out);
                else      @(negedge clk_out);
                edge_hit = 1'b1;
            end
            #(lim);
        join_any
        disable fork;
        ok = edge_hit;
    endtask

    task automatic measure(input string tag, input longint exp_hi, input longint exp_per,
                           output longint t_start);
        bit     ok;
        longint t1;
        wait_clk_out(1'b1, 6000, ok);
        chk({tag, "_rise1"}, longint'(ok), 1);
        t_start = longint'($time);
        wait_clk_out(1'b0, 6000, ok);
        chk({tag, "_fall"}, longint'(ok), 1);
        t1 = longint'($time);
        wait_clk_out(1'b1, 6000, ok);
        chk({tag, "_rise2"}, longint'(ok), 1);
        chk({tag, "_high"}, t1 - t_start, exp_hi);
        chk({tag, "_period"}, longint'($time) - t_start, exp_per);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(posedge clk_in); #1;
        div_val  = v;
        div_load = 1'b1;
        @(posedge clk_in); #1;
        div_load = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1, ts, tw;
        int     c, a0, aw0, e0;
        bit     ok, found;

        rst = 1'b1; enable = 1'b0; div_load = 1'b0; div_val = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_clk_out",  clk_out,  0);
        chk("rst_tick",     tick,     0);
        chk("rst_load_ack", load_ack, 0);
        chk("rst_load_err", load_err, 0);
        rst = 1'b0;

        // default divisor 7
        @(posedge clk_in); #1;
        enable = 1'b1;
        measure("n7", 35, 70, ts);
        c = n_tick;
        wait_clk_out(1'b1, 200, ok);
        chk("n7_ticks_per_period", n_tick - c, 1);

        // load 4 mid-period: current 70 ns period completes, ack at the wrap
        t0 = longint'($time);
        a0 = n_ack; aw0 = n_ackw;
        do_load(8'd4);
        measure("n4", 20, 40, ts);
        chk("n4_apply_at_wrap", ts - t0, 70);
        chk("n4_ack_count", n_ack - a0, 1);
        chk("n4_ack_in_wrap", n_ackw - aw0, 1);

        // rejected loads
        e0 = n_err; a0 = n_ack;
        do_load(8'd1);
        do_load(8'd0);
        measure("rej", 20, 40, ts);
        chk("rej_err_count", n_err - e0, 2);
        chk("rej_no_ack", n_ack - a0, 0);

        // back-to-back loads 9 then 5: only 5 applies, one ack
        wait_clk_out(1'b1, 200, ok);
        t0 = longint'($time);
        a0 = n_ack;
        @(posedge clk_in); #1;
        div_val = 8'd9; div_load = 1'b1;
        @(posedge clk_in); #1;
        div_val = 8'd5;
        @(posedge clk_in); #1;
        div_load = 1'b0;
        measure("b2b", 25, 50, ts);
        chk("b2b_apply_at_wrap", ts - t0, 40);
        chk("b2b_ack_count", n_ack - a0, 1);

        // drop enable at cnt=1: the period finishes, then idle
        wait_clk_out(1'b1, 200, ok);
        t0 = longint'($time);
        c = n_tick;
        @(posedge clk_in); #1;
        enable = 1'b0;
        wait_clk_out(1'b0, 200, ok);
        chk("drain_high", longint'($time) - t0, 25);
        wait_clk_out(1'b1, 200, ok);
        chk("drain_no_rise", longint'(ok), 0);
        chk("drain_ticks", n_tick - c, 1);
        chk("drain_idle_low", clk_out, 0);

        // re-enable during DRAIN keeps the clock continuous
        enable = 1'b1;
        wait_clk_out(1'b1, 200, ok);
        t0 = longint'($time);
        @(posedge clk_in); #1;
        enable = 1'b0;
        @(posedge clk_in); #1;
        enable = 1'b1;
        wait_clk_out(1'b1, 200, ok);
        chk("reen_next_rise", longint'($time) - t0, 50);

        // N=255
        do_load(8'd255);
        measure("n255", 1275, 2550, ts);

        // load 6 in the wrap cycle: held for one more 255 period
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk_in); #1;
            if (tick) found = 1'b1;
        end
        chk("wrap_tick_found", longint'(found), 1);
        tw = longint'($time) + 9;
        a0 = n_ack; aw0 = n_ackw;
        div_val = 8'd6; div_load = 1'b1;
        @(posedge clk_in); #1;
        div_load = 1'b0;
        measure("n6", 30, 60, ts);
        chk("n6_applied_late", ts - tw, 2550);
        chk("n6_ack_count", n_ack - a0, 1);
        chk("n6_ack_in_wrap", n_ackw - aw0, 1);

        // reset while clk_out high with a divisor pending
        wait_clk_out(1'b1, 200, ok);
        t0 = longint'($time);
        do_load(8'd3);
        #2;
        chk("pre_rst_high", clk_out, 1);
        rst = 1'b1;
        #5;
        chk("rst_low_5ns", clk_out, 0);
        a0 = n_ack;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_hold_low", clk_out, 0);
        chk("rst_hold_tick", tick, 0);
        rst = 1'b0;
        measure("post_rst", 35, 70, ts);
        chk("post_rst_no_ack", n_ack - a0, 0);

        // load in IDLE goes live the next cycle
        enable = 1'b0;
        repeat (20) @(posedge clk_in);
        #1;
        chk("idle_low", clk_out, 0);
        @(posedge clk_in); #1;
        div_val = 8'd3; div_load = 1'b1;
        @(posedge clk_in); #1;
        div_load = 1'b0;
        chk("idle_ack", load_ack, 1);
        @(posedge clk_in); #1;
        chk("idle_ack_single", load_ack, 0);
        enable = 1'b1;
        measure("n3", 15, 30, ts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL provide parameter DIV_W, default 8, the divisor register width.
REQ-002 SHALL provide parameter DEFAULT_DIV, default 7, the divisor after reset; legal range 2..2^DIV_W-1, elaboration fails otherwise.
REQ-003 SHALL have port clk_in  input  1  the single input clock; all logic uses its rising edge except the odd-ratio half-cycle flop (REQ-012), which uses its falling edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  run request for the divided clock.
REQ-006 SHALL have port div_val  input  DIV_W  new divisor N, sampled when div_load=1.
REQ-007 SHALL have port div_load  input  1  one-cycle divisor load strobe.
REQ-008 SHALL have port clk_out  output  1  divided clock, 50% duty for both even and odd N.
REQ-009 SHALL have port tick  output  1  one-cycle pulse in the last clk_in cycle of each clk_out period.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse in the cycle a pending divisor becomes active.
REQ-011 SHALL have port load_err  output  1  one-cycle pulse, the cycle after div_load, when div_val<2.

Function
REQ-012 Waveform: counter cnt runs 0..N-1 and wraps; H=floor(N/2); registered p=1 while cnt in [0,H-1]; falling-edge flop n=p delayed by half a clk_in cycle; clk_out=p for even N, p OR n for odd N.
REQ-013 Result: period is exactly N clk_in cycles, high time N/2 cycles (odd N: H+0.5), rising edge aligned to the clk_in rising edge where cnt=0, no glitches.
REQ-014 tick SHALL be 1 exactly in cycles where cnt=N-1 and state is RUN or DRAIN.
REQ-015 FSM states: IDLE (cnt=0, p=0, clk_out=0), RUN, DRAIN.
REQ-016 FSM transitions: IDLE->RUN when enable=1 (first period starts at cnt=0 the next cycle); RUN->DRAIN when enable=0; DRAIN->RUN when enable=1, without disturbing the period in progress; DRAIN->IDLE at cnt=N-1.
REQ-017 Stop: deasserting enable SHALL never truncate a period; the last high and low phases complete in full.
REQ-018 Load: div_load=1 with div_val>=2 writes the value to a pending register and sets pending valid.
REQ-019 Apply in RUN/DRAIN: a pending divisor becomes active at the wrap (cnt N-1->0), with load_ack in the wrap cycle; it never applies mid-period.
REQ-020 Apply in IDLE: a pending divisor becomes active the cycle after div_load, with load_ack in that cycle.
REQ-021 Back-to-back loads: a later valid load before the apply point overwrites the pending value; only one load_ack is issued, for the last value.
REQ-022 Load in wrap cycle: a div_load in the same cycle as a wrap is held pending until the following wrap.
REQ-023 Rejected load: div_val 0 or 1 SHALL leave the active and pending divisors unchanged and pulse load_err.
REQ-024 Counter width: cnt and comparisons SHALL be DIV_W bits; N=2^DIV_W-1 SHALL work without overflow.

Reset
REQ-025 While rst=1 at a clk_in rising edge, the block SHALL set: state=IDLE, cnt=0, active divisor=DEFAULT_DIV, pending invalid, p=0, clk_out=0, tick=0, load_ack=0, load_err=0.
REQ-026 The falling-edge flop n SHALL clear at any clk_in falling edge where rst=1.
REQ-027 Reset asserted mid-period SHALL force clk_out low within half a clk_in cycle and discard any pending divisor.
REQ-028 After rst deasserts, operation SHALL resume per REQ-016.

Verification
REQ-029 Scenario: reset, enable=1, clk_in period 10 ns -> clk_out period 70 ns, high 35 ns, tick once per 70 ns.
REQ-030 Scenario: running at N=7, load 4 mid-period -> current 70 ns period completes, load_ack at the wrap, then 40 ns period, high 20 ns.
REQ-031 Scenario: load 1, then load 0 -> load_err each time, period stays unchanged, no load_ack.
REQ-032 Scenario: N=5, drop enable at cnt=1 -> full 50 ns period with 25 ns high completes, then clk_out=0 and IDLE; re-enable in DRAIN -> continuous clock.
REQ-033 Scenario: N=255 -> period 2550 ns, high 1275 ns; load 6 in a wrap cycle -> applied one period later.
REQ-034 Scenario: rst during clk_out high -> clk_out low within 5 ns, divisor back to 7.
